// File: rtl/vmp_sequencer_if.sv
// vmp_sequencer_if: start / chunk-read / result bundle for vmp_sequencer.
// slave = sequencer side, master = host + memory/datapath side.
interface vmp_sequencer_if #(
    parameter int N         = 10,
    parameter int CHUNK_AW  = 7,
    parameter int ACC_WIDTH = 34
);
    logic                   start_valid;
    logic                   start_ready;
    logic [CHUNK_AW-1:0]    chunk_addr;
    logic                   chunk_en;
    logic [26*N-1:0]        vmp_value;
    logic                   result_valid;
    logic                   result_ready;
    logic [ACC_WIDTH*N-1:0] result_sums;
    logic [3:0]             result_class;

    modport slave (
        input  start_valid,
        output start_ready,
        output chunk_addr,
        output chunk_en,
        input  vmp_value,
        output result_valid,
        input  result_ready,
        output result_sums,
        output result_class
    );

    modport master (
        output start_valid,
        input  start_ready,
        input  chunk_addr,
        input  chunk_en,
        output vmp_value,
        input  result_valid,
        output result_ready,
        input  result_sums,
        input  result_class
    );
endinterface

// File: rtl/vmp_sequencer.sv
// vmp_sequencer: issues NUM_CHUNKS chunk reads per image, accumulates the
// N signed lane results PIPE_LAT cycles later, reduces, presents result.
// Ports: clk, GlobalReset (sync, active high), bus (vmp_sequencer_if.slave:
//   start_valid/ready, chunk_addr/en, vmp_value, result_valid/ready/sums/class).
// Option: define VMP_SEQ_ARGMAX_EN for a serial argmax in REDUCE (N cycles);
//   otherwise REDUCE is one cycle and result_class is 0.
module vmp_sequencer #(
    parameter int N          = 10,
    parameter int NUM_CHUNKS = 79,
    parameter int CHUNK_AW   = 7,
    parameter int PIPE_LAT   = 3,
    parameter int ACC_WIDTH  = 34
) (
    input logic           clk,
    input logic           GlobalReset,
    vmp_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        REDUCE,
        DONE
    } state_e;

    localparam logic [CHUNK_AW-1:0] LAST_CHUNK = CHUNK_AW'(NUM_CHUNKS - 1);
    // Pipe pattern when only the final chunk is still in flight, at its tap.
    localparam logic [PIPE_LAT-1:0] LAST_TAG = PIPE_LAT'(1) << (PIPE_LAT - 1);

    state_e                 state_q, state_d;
    logic [CHUNK_AW-1:0]    cnt_q, cnt_d;
    logic [PIPE_LAT-1:0]    vpipe_q, vpipe_d;
    logic [ACC_WIDTH-1:0]   acc_q [N];
    logic [ACC_WIDTH-1:0]   acc_d [N];
`ifdef VMP_SEQ_ARGMAX_EN
    logic [3:0]             red_q, red_d;
    logic [3:0]             cls_q, cls_d;
    logic [ACC_WIDTH-1:0]   best_q, best_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        vpipe_d = vpipe_q << 1;
`ifdef VMP_SEQ_ARGMAX_EN
        red_d   = red_q;
        cls_d   = cls_q;
        best_d  = best_q;
`endif
        vpipe_d[0] = (state_q == ISSUE);

        // Oldest pipe stage marks the cycle vmp_value belongs to a chunk.
        if (vpipe_q[PIPE_LAT-1]) begin
            for (int j = 0; j < N; j++) begin
                acc_d[j] = acc_q[j] + {{(ACC_WIDTH-26){bus.vmp_value[26*j+25]}},
                                       bus.vmp_value[26*j +: 26]};
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                    for (int j = 0; j < N; j++) begin
                        acc_d[j] = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CHUNK) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (vpipe_q == LAST_TAG) begin
                    state_d = REDUCE;
`ifdef VMP_SEQ_ARGMAX_EN
                    red_d   = '0;
`endif
                end
            end
            REDUCE: begin
`ifdef VMP_SEQ_ARGMAX_EN
                // Strict greater-than keeps the lowest index on ties.
                if (red_q == 4'd0 ||
                    $signed(acc_q[red_q]) > $signed(best_q)) begin
                    best_d = acc_q[red_q];
                    cls_d  = red_q;
                end
                if (red_q == 4'(N - 1)) begin
                    state_d = DONE;
                end else begin
                    red_d = red_q + 4'd1;
                end
`else
                state_d = DONE;
`endif
            end
            DONE: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vpipe_q <= '0;
            for (int j = 0; j < N; j++) begin
                acc_q[j] <= '0;
            end
`ifdef VMP_SEQ_ARGMAX_EN
            red_q   <= '0;
            cls_q   <= '0;
            best_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vpipe_q <= vpipe_d;
            for (int j = 0; j < N; j++) begin
                acc_q[j] <= acc_d[j];
            end
`ifdef VMP_SEQ_ARGMAX_EN
            red_q   <= red_d;
            cls_q   <= cls_d;
            best_q  <= best_d;
`endif
        end
    end

    always_comb begin
        bus.start_ready  = (state_q == IDLE);
        bus.chunk_en     = (state_q == ISSUE);
        bus.chunk_addr   = (state_q == ISSUE) ? cnt_q : '0;
        bus.result_valid = (state_q == DONE);
        for (int j = 0; j < N; j++) begin
            bus.result_sums[ACC_WIDTH*j +: ACC_WIDTH] = acc_q[j];
        end
`ifdef VMP_SEQ_ARGMAX_EN
        bus.result_class = cls_q;
`else
        bus.result_class = 4'd0;
`endif
    end
endmodule

// File: tb/tb_vmp_sequencer.sv
// tb_vmp_sequencer: directed image runs against a transaction-level model
// of vmp_sequencer, with a memory model returning chunk data PIPE_LAT later.
module tb_vmp_sequencer;
    localparam int N          = 10;
    localparam int NUM_CHUNKS = 79;
    localparam int CHUNK_AW   = 7;
    localparam int PIPE_LAT   = 3;
    localparam int ACC_WIDTH  = 34;
`ifdef VMP_SEQ_ARGMAX_EN
    localparam int RED_CYC    = N;
    localparam int LAT_LIT    = 93;
    localparam int CLS1_LIT   = 9;
`else
    localparam int RED_CYC    = 1;
    localparam int LAT_LIT    = 84;
    localparam int CLS1_LIT   = 0;
`endif
    localparam int LAT = NUM_CHUNKS + PIPE_LAT + RED_CYC + 1;

    logic clk = 1'b0;
    logic GlobalReset;
    always #5 clk = ~clk;

    vmp_sequencer_if #(.N(N), .CHUNK_AW(CHUNK_AW), .ACC_WIDTH(ACC_WIDTH)) bus();

    vmp_sequencer #(
        .N(N), .NUM_CHUNKS(NUM_CHUNKS), .CHUNK_AW(CHUNK_AW),
        .PIPE_LAT(PIPE_LAT), .ACC_WIDTH(ACC_WIDTH)
    ) dut (
        .clk(clk),
        .GlobalReset(GlobalReset),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Image held by the memory model: img[chunk][lane].
    logic [25:0] img [NUM_CHUNKS][N];

    function automatic logic [ACC_WIDTH-1:0] lane(input int j);
        return bus.result_sums[ACC_WIDTH*j +: ACC_WIDTH];
    endfunction

    function automatic logic [ACC_WIDTH-1:0] model_sum(input int j);
        longint s = 0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            s += longint'($signed(img[c][j]));
        end
        return s[ACC_WIDTH-1:0];
    endfunction

    function automatic logic [3:0] model_cls();
        int best = 0;
`ifdef VMP_SEQ_ARGMAX_EN
        for (int j = 1; j < N; j++) begin
            if ($signed(model_sum(j)) > $signed(model_sum(best))) best = j;
        end
`endif
        return 4'(best);
    endfunction

    task automatic fill(input int p);
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            for (int j = 0; j < N; j++) begin
                case (p)
                    1: img[c][j] = 26'(j + 1);
                    2: img[c][j] = 26'h3FFFFFF;
                    default: img[c][j] = ((c + j) % 3 == 0) ? 26'h2000000 :
                                         26'((c * 131 + j * 17) % 4096);
                endcase
            end
        end
    endtask

    // Memory model: a chunk read in cycle c returns img data in c+PIPE_LAT;
    // any other cycle carries random junk that must not be accumulated.
    logic                cap_en = 1'b0;
    logic [CHUNK_AW-1:0] cap_addr = '0;
    logic                dl_en   [PIPE_LAT];
    logic [CHUNK_AW-1:0] dl_addr [PIPE_LAT];

    initial begin
        for (int i = 0; i < PIPE_LAT; i++) begin
            dl_en[i] = 1'b0;
            dl_addr[i] = '0;
        end
        bus.vmp_value = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                dl_en[i] = dl_en[i-1];
                dl_addr[i] = dl_addr[i-1];
            end
            dl_en[0] = cap_en;
            dl_addr[0] = cap_addr;
            for (int j = 0; j < N; j++) begin
                if (dl_en[PIPE_LAT-1])
                    bus.vmp_value[26*j +: 26] = img[dl_addr[PIPE_LAT-1]][j];
                else
                    bus.vmp_value[26*j +: 26] = 26'($urandom);
            end
        end
    end

    // Transaction model + per-cycle compare. k counts cycles since accept.
    bit                   armed = 0;
    bit                   busy = 0;
    bit                   done = 0;
    int                   k = 0;
    logic [ACC_WIDTH-1:0] exp_sum [N];
    logic [3:0]           exp_cls = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                check("start_ready", bus.start_ready, !busy && !done);
                check("chunk_en", bus.chunk_en, busy && k <= NUM_CHUNKS);
                check("chunk_addr", bus.chunk_addr,
                      (busy && k <= NUM_CHUNKS) ? 64'(k - 1) : 64'd0);
                check("result_valid", bus.result_valid, done);
                if (done) begin
                    for (int j = 0; j < N; j++) check("sum", lane(j), exp_sum[j]);
                    check("class", bus.result_class, exp_cls);
                end
            end
            cap_en = bus.chunk_en;
            cap_addr = bus.chunk_addr;
            if (GlobalReset) begin
                busy = 0;
                done = 0;
                armed = 1;
            end else if (!busy && !done) begin
                if (bus.start_valid) begin
                    busy = 1;
                    k = 1;
                    for (int j = 0; j < N; j++) exp_sum[j] = model_sum(j);
                    exp_cls = model_cls();
                end
            end else if (busy) begin
                if (k + 1 == LAT) begin
                    busy = 0;
                    done = 1;
                end else begin
                    k++;
                end
            end else if (bus.result_ready) begin
                done = 0;
            end
        end
    end

    task automatic start_img();
        bus.start_valid = 1'b1;
        for (int i = 0; i < 10 && !bus.start_ready; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int en);
        cyc = 1;
        en = 0;
        forever begin
            if (bus.chunk_en) en++;
            if (bus.result_valid || cyc >= 1000) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!bus.result_valid) check("timeout", 0, 1);
    endtask

    task automatic release_res(input int hold);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
    endtask

    int cyc;
    int en;
    int n;

    initial begin
        GlobalReset = 1'b1;
        bus.start_valid = 1'b0;
        bus.result_ready = 1'b0;
        fill(1);
        repeat (2) @(posedge clk);
        #1;
        GlobalReset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_start_ready", bus.start_ready, 1);
        check("rst_chunk_en", bus.chunk_en, 0);
        check("rst_chunk_addr", bus.chunk_addr, 0);
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_class", bus.result_class, 0);
        check("rst_sum0", lane(0), 0);

        // Lane j = j+1 on every chunk.
        start_img();
        wait_done(cyc, en);
        check("lat_ramp", cyc, LAT_LIT);
        check("en_ramp", en, 79);
        check("ramp_sum0", lane(0), 79);
        check("ramp_sum9", lane(9), 790);
        check("ramp_class", bus.result_class, CLS1_LIT);
        release_res(0);

        // All lanes -1; hold result 20 cycles with start pulses.
        fill(2);
        start_img();
        wait_done(cyc, en);
        check("neg_sum0", lane(0), 34'h3FFFFFFB1);
        check("neg_sum5", lane(5), 34'h3FFFFFFB1);
        check("neg_class", bus.result_class, 0);
        for (int i = 0; i < 20; i++) begin
            bus.start_valid = (i % 3 == 0);
            @(posedge clk);
            #1;
            check("hold_ready", bus.start_ready, 0);
            check("hold_valid", bus.result_valid, 1);
        end
        bus.start_valid = 1'b0;
        release_res(0);
        check("post_ready", bus.start_ready, 1);
        check("post_valid", bus.result_valid, 0);

        // Mixed magnitudes including the most negative lane value.
        fill(3);
        start_img();
        wait_done(cyc, en);
        check("mix_lat", cyc, LAT_LIT);
        release_res(3);

        // Reset at chunk 40, then a fresh image.
        fill(2);
        start_img();
        n = 0;
        while (!(bus.chunk_en && bus.chunk_addr == 7'd40) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("saw_addr40", bus.chunk_addr, 40);
        GlobalReset = 1'b1;
        @(posedge clk);
        #1;
        GlobalReset = 1'b0;
        check("mid_rst_ready", bus.start_ready, 1);
        check("mid_rst_en", bus.chunk_en, 0);
        check("mid_rst_valid", bus.result_valid, 0);
        check("mid_rst_sum3", lane(3), 0);
        fill(1);
        start_img();
        wait_done(cyc, en);
        check("fresh_sum4", lane(4), 395);
        check("fresh_lat", cyc, LAT_LIT);

        // Start held during the DONE->IDLE handshake.
        bus.result_ready = 1'b1;
        bus.start_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
        check("b2b_ready", bus.start_ready, 1);
        check("b2b_en", bus.chunk_en, 0);
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        wait_done(cyc, en);
        check("b2b_en_cnt", en, 79);
        check("b2b_lat", cyc, LAT_LIT);
        check("b2b_sum9", lane(9), 790);
        release_res(0);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
